fetch_unit: RTL

Instruction fetch stage sitting directly upstream of the byte-addressable `memory` block. Holds the program counter, issues single-word big-endian read requests (access_size 2'b00) to `memory`, absorbs `busy` back-pressure, and delivers {pc, instruction} pairs to decode through a 2-entry buffer with a valid/stall handshake. Supports a one-cycle redirect for branches/jumps, and faults on misaligned or out-of-range PCs.

---
 rtl/fetch_unit.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Holds the PC, issues single-word reads
// to memory, absorbs busy back-pressure and hands {pc, insn} pairs to decode
// through a 2-entry buffer. Supports one-cycle redirects and a sticky fault on
// misaligned or out-of-range PCs.
module fetch_unit #(
  parameter int unsigned              address_width = 32,
  parameter int unsigned              data_width    = 32,
  parameter logic [address_width-1:0] start_addr    = 32'h8002_0000,
  parameter int unsigned              depth         = 1048576
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     stall,
  input  logic                     redirect,
  input  logic [address_width-1:0] redirect_pc,
  input  logic                     mem_busy,
  input  logic [data_width-1:0]    mem_data_out,
  output logic [address_width-1:0] mem_address,
  output logic [data_width-1:0]    mem_data_in,
  output logic [1:0]               mem_access_size,
  output logic                     mem_rw,
  output logic                     mem_enable,
  output logic [data_width-1:0]    insn,
  output logic [address_width-1:0] insn_pc,
  output logic                     insn_valid,
  output logic                     fault
);

  localparam logic [address_width-1:0] last_addr = start_addr + address_width'(depth - 4);
  localparam logic [address_width-1:0] pc_step   = address_width'(4);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    CAPTURE = 3'd2,
    HOLD    = 3'd3,
    FAULT   = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic [address_width-1:0] pc_q, pc_d;
  logic                     enable_q, enable_d;
  logic                     fault_q;

  // buffer: slot 0 is the head and drives the decode outputs directly
  logic                     v0_q, v1_q;
  logic [data_width-1:0]    s0_insn_q, s1_insn_q;
  logic [address_width-1:0] s0_pc_q, s1_pc_q;

  logic pop, push, flush, free_after;

  // word-aligned and inside [start_addr, start_addr+depth-4]
  function automatic logic pc_legal(input logic [address_width-1:0] a);
    return (a >= start_addr) && (a <= last_addr) && (a[1:0] == 2'b00);
  endfunction

  // next-state, next-PC and buffer push/flush decisions
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    push       = 1'b0;
    flush      = 1'b0;
    pop        = v0_q && !stall;
    // a slot is free after this edge's push if nothing remains after the pop
    free_after = !v0_q || (!v1_q && pop);

    case (state_q)
      IDLE:    state_d = ISSUE;
      ISSUE:   state_d = pc_legal(pc_q) ? CAPTURE : FAULT;
      CAPTURE: begin
        if (!mem_busy) begin
          push    = 1'b1;
          pc_d    = pc_q + pc_step;
          state_d = free_after ? ISSUE : HOLD;
        end
      end
      HOLD:    if (pop) state_d = ISSUE;
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase

    // redirect overrides everything except a latched fault
    if (redirect && (state_q != FAULT)) begin
      flush   = 1'b1;
      push    = 1'b0;
      pc_d    = redirect_pc;
      state_d = ISSUE;
    end

    // request is raised only for a legal ISSUE and held through CAPTURE
    enable_d = ((state_d == ISSUE) && pc_legal(pc_d)) || (state_d == CAPTURE);
  end

  // FSM state, PC and registered memory request
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      pc_q     <= start_addr;
      enable_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      enable_q <= enable_d;
      fault_q  <= (state_d == FAULT);
    end
  end

  // 2-entry FIFO with simultaneous push/pop
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v0_q      <= 1'b0;
      v1_q      <= 1'b0;
      s0_insn_q <= '0;
      s0_pc_q   <= '0;
      s1_insn_q <= '0;
      s1_pc_q   <= '0;
    end else if (flush) begin
      v0_q <= 1'b0;
      v1_q <= 1'b0;
    end else if (pop) begin
      if (v1_q) begin
        s0_insn_q <= s1_insn_q;
        s0_pc_q   <= s1_pc_q;
        if (push) begin
          s1_insn_q <= mem_data_out;
          s1_pc_q   <= pc_q;
        end else begin
          v1_q <= 1'b0;
        end
      end else if (push) begin
        s0_insn_q <= mem_data_out;
        s0_pc_q   <= pc_q;
      end else begin
        v0_q <= 1'b0;
      end
    end else if (push) begin
      if (!v0_q) begin
        s0_insn_q <= mem_data_out;
        s0_pc_q   <= pc_q;
        v0_q      <= 1'b1;
      end else begin
        s1_insn_q <= mem_data_out;
        s1_pc_q   <= pc_q;
        v1_q      <= 1'b1;
      end
    end
  end

  assign mem_address     = pc_q;
  assign mem_enable      = enable_q;
  assign mem_data_in     = '0;
  assign mem_access_size = 2'b00;
  assign mem_rw          = 1'b1;
  assign insn            = s0_insn_q;
  assign insn_pc         = s0_pc_q;
  assign insn_valid      = v0_q;
  assign fault           = fault_q;

endmodule
